fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the 5-stage RV32I core. The block owns the fetch PC and runs a single-outstanding req/ack handshake to instruction memory. It absorbs decode stalls and execute-stage redirects, and drives the registered instruction with its Op/funct3/funct7 fields straight into the decode-stage control unit.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; word-aligned.
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- PCSrcE  in  1  taken branch/jump redirect from execute.
- PCTargetE  in  32  redirect target; bits [1:0] forced to 0.
- StallD  in  1  hold IF/ID contents (hazard unit).
- FlushD  in  1  replace IF/ID with bubble (hazard unit).
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, stable while imem_req=1 and no ack.
- imem_ack  in  1  data valid this cycle; may assert in the same cycle as imem_req.
- imem_rdata  in  32  instruction word, sampled only when imem_ack=1.
- InstrD  out  32  registered instruction.
- OpD, funct3D, funct7D  out  7/3/7  InstrD[6:0], [14:12], [31:25].
- PCD, PCPlus4D  out  32  PC of InstrD and PC+4.
- ValidD  out  1  InstrD is a real instruction.

## Operation
- Registers:
  - PCF: next fetch PC.
  - StaleAddr: address of an abandoned request.
  - HoldInstr/HoldPC: one-entry hold buffer.
  - State.
- States:
  - REQ: imem_req=1, imem_addr=PCF.
  - DRAIN: imem_req=1, imem_addr=StaleAddr; returned data discarded.
  - HOLD: imem_req=0; instruction parked in hold buffer.
- Transitions, PCSrcE=0:
  - REQ & ack & !StallD: IF/ID <= {rdata, PCF, PCF+4, valid}; PCF += 4; stay REQ.
  - REQ & ack & StallD: hold buffer <= {rdata, PCF}; PCF += 4; go HOLD.
  - REQ & !ack: stay.
  - HOLD & !StallD: IF/ID <= hold buffer; go REQ.
  - DRAIN & ack: go REQ.
- Transitions, PCSrcE=1 (highest priority): PCF <= {PCTargetE[31:2],2'b00}; hold buffer invalidated.
  - REQ & !ack: StaleAddr <= PCF; go DRAIN.
  - REQ & ack: data discarded; stay REQ.
  - HOLD: go REQ.
  - DRAIN & !ack: stay DRAIN; newest target wins.
  - DRAIN & ack: go REQ.
- IF/ID update priority: (FlushD | PCSrcE) > StallD > load > bubble.
  - Bubble = InstrD 32'h0000_0013 (addi x0,x0,0), ValidD=0; PCD/PCPlus4D hold their last values.
  - No ack in REQ and no HOLD drain while !StallD: bubble.
- PCF arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - PCF=RESET_PC; State=REQ; StaleAddr=0.
  - InstrD=32'h0000_0013; PCD=0; PCPlus4D=0; ValidD=0; hold buffer empty.
  - imem_req=0 while rst=0; 1 from the first cycle after release.
- Latency: a request acked in cycle N appears on IF/ID outputs after edge N.
  - Zero-wait memory sustains 1 instruction/cycle.
  - Each wait cycle inserts one bubble.
- imem_req and imem_addr are functions of registers only; no combinational path from any input.
- Redirect cost: PCSrcE in cycle N gives a new-target request in cycle N+1 from REQ/HOLD, or after the stale ack from DRAIN.
- Reset mid-request: the request is abandoned immediately. The memory must accept imem_req dropping without ack.
- StallD held indefinitely in HOLD: no new request; InstrD and the hold buffer are preserved.

## Configuration
- FETCH_PERF_CNT_EN defined: adds output fetch_wait_cnt [31:0].
  - Increments each cycle with imem_req=1 & imem_ack=0; saturates at 32'hFFFF_FFFF.
  - Reset to 0.
- FETCH_PERF_CNT_EN undefined: port and counter are absent; behaviour otherwise identical.

## Test plan
- Release reset, zero-wait ack, memory returns addr as data -> ValidD rises after edge 1 with PCD=0, then 4, 8, ... every cycle; imem_addr low during reset.
- Ack delayed 2 cycles per fetch -> two bubbles (InstrD=32'h13, ValidD=0) between instructions; imem_addr stable across waits.
- StallD high 3 cycles while ack arrives for PC 0x10 -> HOLD entered, imem_req=0, InstrD unchanged; after StallD falls InstrD=word@0x10, PCD=0x10, next fetch 0x14.
- PCSrcE=1, PCTargetE=0x103 while request to 0x20 pending -> DRAIN, ack for 0x20 discarded, next imem_addr=0x100, ValidD=0 for the flush cycle.
- FlushD and StallD both high -> IF/ID becomes bubble; assert rst mid-request -> all outputs at reset values within the same cycle.
- With FETCH_PERF_CNT_EN, 5 wait cycles -> fetch_wait_cnt=5; compiled without it -> port absent, elaborates clean.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage with IF/ID pipeline register: owns the fetch PC, single-outstanding imem req/ack.
// Optional feature: define FETCH_PERF_CNT_EN to add the fetch_wait_cnt stall counter output.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] fetch_wait_cnt,
`endif
  input  logic        clk,
  input  logic        rst,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [6:0]  OpD,
  output logic [2:0]  funct3D,
  output logic [6:0]  funct7D,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {REQ = 2'd0, DRAIN = 2'd1, HOLD = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic        run_reg;
  logic [31:0] pcf_reg, pcf_next;
  logic [31:0] stale_reg, stale_next;
  logic [31:0] hold_instr_reg, hold_instr_next;
  logic [31:0] hold_pc_reg, hold_pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] pcd_reg, pcd_next;
  logic [31:0] pcp4_reg, pcp4_next;
  logic        valid_reg, valid_next;

  logic        acked;
  logic        load;
  logic [31:0] load_instr, load_pc;
  logic [31:0] target;
  logic        unused_target_bits;

  // run_reg keeps the request low until the first edge after reset release.
  assign imem_req  = run_reg && (state_reg != HOLD);
  assign imem_addr = (state_reg == DRAIN) ? stale_reg : pcf_reg;
  assign acked     = imem_req && imem_ack;
  assign target    = {PCTargetE[31:2], 2'b00};
  assign unused_target_bits = ^PCTargetE[1:0];

  always_comb begin
    state_next      = state_reg;
    pcf_next        = pcf_reg;
    stale_next      = stale_reg;
    hold_instr_next = hold_instr_reg;
    hold_pc_next    = hold_pc_reg;
    load            = 1'b0;
    load_instr      = imem_rdata;
    load_pc         = pcf_reg;
    case (state_reg)
      REQ: begin
        if (PCSrcE) begin
          pcf_next = target;
          if (imem_req && !imem_ack) begin
            stale_next = pcf_reg;
            state_next = DRAIN;
          end
        end else if (acked) begin
          pcf_next = pcf_reg + 32'd4;
          if (StallD) begin
            hold_instr_next = imem_rdata;
            hold_pc_next    = pcf_reg;
            state_next      = HOLD;
          end else begin
            load = 1'b1;
          end
        end
      end
      HOLD: begin
        if (PCSrcE) begin
          pcf_next   = target;
          state_next = REQ;
        end else if (!StallD) begin
          load       = 1'b1;
          load_instr = hold_instr_reg;
          load_pc    = hold_pc_reg;
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (PCSrcE) pcf_next = target;
        if (acked) state_next = REQ;
      end
      default: state_next = REQ;
    endcase
  end

  always_comb begin
    instr_next = instr_reg;
    pcd_next   = pcd_reg;
    pcp4_next  = pcp4_reg;
    valid_next = valid_reg;
    if (FlushD || PCSrcE) begin
      instr_next = NOP;
      valid_next = 1'b0;
    end else if (StallD) begin
      valid_next = valid_reg;
    end else if (load) begin
      instr_next = load_instr;
      pcd_next   = load_pc;
      pcp4_next  = load_pc + 32'd4;
      valid_next = 1'b1;
    end else begin
      instr_next = NOP;
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= REQ;
      run_reg        <= 1'b0;
      pcf_reg        <= RESET_PC;
      stale_reg      <= 32'd0;
      hold_instr_reg <= 32'd0;
      hold_pc_reg    <= 32'd0;
      instr_reg      <= NOP;
      pcd_reg        <= 32'd0;
      pcp4_reg       <= 32'd0;
      valid_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      run_reg        <= 1'b1;
      pcf_reg        <= pcf_next;
      stale_reg      <= stale_next;
      hold_instr_reg <= hold_instr_next;
      hold_pc_reg    <= hold_pc_next;
      instr_reg      <= instr_next;
      pcd_reg        <= pcd_next;
      pcp4_reg       <= pcp4_next;
      valid_reg      <= valid_next;
    end
  end

  assign InstrD   = instr_reg;
  assign OpD      = instr_reg[6:0];
  assign funct3D  = instr_reg[14:12];
  assign funct7D  = instr_reg[31:25];
  assign PCD      = pcd_reg;
  assign PCPlus4D = pcp4_reg;
  assign ValidD   = valid_reg;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] wait_cnt_reg;

  // Saturating count of cycles spent waiting on instruction memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= 32'd0;
    end else if (imem_req && !imem_ack && (wait_cnt_reg != 32'hFFFF_FFFF)) begin
      wait_cnt_reg <= wait_cnt_reg + 32'd1;
    end
  end

  assign fetch_wait_cnt = wait_cnt_reg;
`else
  // No performance counter in this build.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal expectations, then
// randomized stimulus against a transaction-level model (define FETCH_PERF_CNT_EN to cover the counter).
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallD;
  logic        FlushD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [6:0]  OpD;
  logic [2:0]  funct3D;
  logic [6:0]  funct7D;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_wait_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: fetch PC, stale request, parked instruction, IF/ID contents.
  logic        m_run;
  logic [31:0] m_pc;
  logic        m_drain;
  logic [31:0] m_stale;
  logic        m_park_v;
  logic [31:0] m_park_i, m_park_pc;
  logic [31:0] m_instr, m_pcd, m_pcp4;
  logic        m_valid;
  logic [31:0] m_wait;

  always #5 clk = ~clk;

  fetch_stage dut (
`ifdef FETCH_PERF_CNT_EN
    .fetch_wait_cnt(fetch_wait_cnt),
`endif
    .clk(clk),
    .rst(rst),
    .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE),
    .StallD(StallD),
    .FlushD(FlushD),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .InstrD(InstrD),
    .OpD(OpD),
    .funct3D(funct3D),
    .funct7D(funct7D),
    .PCD(PCD),
    .PCPlus4D(PCPlus4D),
    .ValidD(ValidD)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pc = 32'd0; m_drain = 0; m_stale = 32'd0;
    m_park_v = 0; m_park_i = 32'd0; m_park_pc = 32'd0;
    m_instr = NOP; m_pcd = 32'd0; m_pcp4 = 32'd0; m_valid = 0; m_wait = 32'd0;
  endtask

  task automatic check_model();
    logic exp_req;
    exp_req = m_run && !m_park_v;
    chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, m_drain ? m_stale : m_pc);
    chk("InstrD", InstrD, m_instr);
    chk("OpD", {25'd0, OpD}, {25'd0, m_instr[6:0]});
    chk("funct3D", {29'd0, funct3D}, {29'd0, m_instr[14:12]});
    chk("funct7D", {25'd0, funct7D}, {25'd0, m_instr[31:25]});
    chk("PCD", PCD, m_pcd);
    chk("PCPlus4D", PCPlus4D, m_pcp4);
    chk("ValidD", {31'd0, ValidD}, {31'd0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_wait_cnt", fetch_wait_cnt, m_wait);
`endif
  endtask

  task automatic model_step(input logic rd, input logic [31:0] tg, input logic st,
                            input logic fl, input logic ak, input logic [31:0] rdata);
    logic        req_now, acked, ld;
    logic [31:0] ld_i, ld_pc, tgt;
    req_now = m_run && !m_park_v;
    acked   = req_now && ak;
    ld = 0; ld_i = 32'd0; ld_pc = 32'd0;
    tgt = tg & 32'hFFFF_FFFC;
    if (req_now && !ak && m_wait != 32'hFFFF_FFFF) m_wait = m_wait + 1;
    if (m_park_v) begin
      if (rd) begin
        m_park_v = 0; m_pc = tgt;
      end else if (!st) begin
        ld = 1; ld_i = m_park_i; ld_pc = m_park_pc; m_park_v = 0;
      end
    end else if (m_drain) begin
      if (rd) m_pc = tgt;
      if (acked) m_drain = 0;
    end else begin
      if (rd) begin
        if (req_now && !ak) begin
          m_drain = 1; m_stale = m_pc;
        end
        m_pc = tgt;
      end else if (acked) begin
        if (st) begin
          m_park_v = 1; m_park_i = rdata; m_park_pc = m_pc;
        end else begin
          ld = 1; ld_i = rdata; ld_pc = m_pc;
        end
        m_pc = m_pc + 32'd4;
      end
    end
    if (fl || rd) begin
      m_instr = NOP; m_valid = 0;
    end else if (!st) begin
      if (ld) begin
        m_instr = ld_i; m_pcd = ld_pc; m_pcp4 = ld_pc + 32'd4; m_valid = 1;
      end else begin
        m_instr = NOP; m_valid = 0;
      end
    end
    m_run = 1;
  endtask

  // Called at a falling edge: check, drive one cycle of inputs, advance to the next falling edge.
  task automatic cycle(input logic rd, input logic [31:0] tg, input logic st,
                       input logic fl, input logic ak);
    check_model();
    PCSrcE = rd; PCTargetE = tg; StallD = st; FlushD = fl; imem_ack = ak;
    imem_rdata = ak ? mem(imem_addr) : $urandom();
    model_step(rd, tg, st, fl, ak, imem_rdata);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 0; PCSrcE = 0; PCTargetE = 32'd0; StallD = 0; FlushD = 0;
    imem_ack = 0; imem_rdata = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_instr", InstrD, NOP);
    check_model();
    rst = 1;

    // Zero-wait fetch from reset.
    cycle(0, 0, 0, 0, 1);
    chk("rel_req", {31'd0, imem_req}, 32'd1);
    chk("rel_addr", imem_addr, 32'h0);
    cycle(0, 0, 0, 0, 1);
    chk("zw0_pcd", PCD, 32'h0);
    chk("zw0_p4", PCPlus4D, 32'h4);
    chk("zw0_valid", {31'd0, ValidD}, 32'd1);
    cycle(0, 0, 0, 0, 1);
    chk("zw1_pcd", PCD, 32'h4);
    cycle(0, 0, 0, 0, 1);
    chk("zw2_pcd", PCD, 32'h8);
    chk("zw2_instr", InstrD, 32'hC0DE_0008);

    // Two wait cycles before the ack.
    cycle(0, 0, 0, 0, 0);
    chk("w1_instr", InstrD, NOP);
    chk("w1_addr", imem_addr, 32'hC);
    cycle(0, 0, 0, 0, 0);
    chk("w2_valid", {31'd0, ValidD}, 32'd0);
    chk("w2_addr", imem_addr, 32'hC);
    cycle(0, 0, 0, 0, 1);
    chk("w_pcd", PCD, 32'hC);

    // Stall while the fetch of 0x10 completes.
    cycle(0, 0, 1, 0, 1);
    chk("st_req", {31'd0, imem_req}, 32'd0);
    chk("st_instr", InstrD, 32'hC0DE_000C);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 1, 0, 1);
    chk("st3_req", {31'd0, imem_req}, 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("un_instr", InstrD, 32'hC0DE_0010);
    chk("un_pcd", PCD, 32'h10);
    chk("un_addr", imem_addr, 32'h14);

    // Redirect while a request to 0x20 is pending.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    chk("pre_addr", imem_addr, 32'h20);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 32'h103, 0, 0, 0);
    chk("dr_addr", imem_addr, 32'h20);
    chk("dr_valid", {31'd0, ValidD}, 32'd0);
    cycle(0, 0, 0, 0, 1);
    chk("dr_new_addr", imem_addr, 32'h100);
    chk("dr_disc_valid", {31'd0, ValidD}, 32'd0);
    cycle(0, 0, 0, 0, 1);
    chk("tg_pcd", PCD, 32'h100);

    // Flush and stall together give a bubble.
    cycle(0, 0, 1, 1, 0);
    chk("fs_instr", InstrD, NOP);
    chk("fs_valid", {31'd0, ValidD}, 32'd0);
    chk("fs_pcd", PCD, 32'h100);

    // PC wrap at the top of the address space.
    cycle(1, 32'hFFFF_FFFF, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    chk("wr_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 1);
    chk("wr_pcd", PCD, 32'hFFFF_FFFC);
    chk("wr_p4", PCPlus4D, 32'h0);
    chk("wr_next", imem_addr, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_lit", fetch_wait_cnt, 32'd6);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(15) == 0, $urandom(), $urandom_range(3) == 0,
            $urandom_range(15) == 0, $urandom_range(1) == 1);
    end

    // Reset asserted in the middle of an outstanding request.
    cycle(0, 0, 0, 0, 0);
    PCSrcE = 0; StallD = 0; FlushD = 0; imem_ack = 0;
    @(posedge clk);
    #2 rst = 0;
    #1;
    chk("mr_req", {31'd0, imem_req}, 32'd0);
    chk("mr_addr", imem_addr, 32'd0);
    chk("mr_instr", InstrD, NOP);
    chk("mr_valid", {31'd0, ValidD}, 32'd0);
    chk("mr_pcd", PCD, 32'd0);
    chk("mr_p4", PCPlus4D, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 0, $urandom_range(1) == 1);
    end
    check_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
